atan2_ratio_div: RTL and testbench



---
 rtl/atan2_ratio_div.sv | 171 +++++++++++++++++
 tb/tb_atan2_ratio_div.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/atan2_ratio_div.sv
// atan2_ratio_div: binary32 y/x pre-stage for the Atan pipeline.
// Iterative restoring mantissa divider, one quotient bit per clock,
// with x/y sign sideband for downstream quadrant correction.
module atan2_ratio_div #(
  parameter int unsigned QBITS     = 26,
  parameter logic [31:0] NAN_CANON = 32'h7fc00000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_y,
  input  logic [31:0] io_in_x,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_q,
  output logic        io_out_xneg,
  output logic        io_out_yneg
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

  state_t             state;
  logic [31:0]        y_r, x_r;
  logic [23:0]        mx;
  logic [24:0]        rem;
  logic [QBITS-1:0]   quo;
  logic signed [9:0]  e;
  logic [4:0]         cnt;

  logic               sign;
  logic               y_zero, y_inf, y_nan, x_zero, x_inf, x_nan;
  logic               special;
  logic [31:0]        special_q;
  logic signed [9:0]  e_unpack;

  // Operand classification and special-case result (denormals read as zero)
  always_comb begin
    sign      = y_r[31] ^ x_r[31];
    y_zero    = (y_r[30:23] == 8'h00);
    y_inf     = (y_r[30:23] == 8'hff) && (y_r[22:0] == '0);
    y_nan     = (y_r[30:23] == 8'hff) && (y_r[22:0] != '0);
    x_zero    = (x_r[30:23] == 8'h00);
    x_inf     = (x_r[30:23] == 8'hff) && (x_r[22:0] == '0);
    x_nan     = (x_r[30:23] == 8'hff) && (x_r[22:0] != '0);
    e_unpack  = $signed({2'b00, y_r[30:23]}) - $signed({2'b00, x_r[30:23]}) + 10'sd127;
    special   = 1'b1;
    special_q = '0;
    if (y_nan || x_nan || (y_inf && x_inf))
      special_q = NAN_CANON;
    else if (x_zero && y_zero)
      special_q = '0;
    else if (x_zero || y_inf)
      special_q = {sign, 8'hff, 23'd0};
    else if (x_inf || y_zero)
      special_q = {sign, 31'd0};
    else
      special = 1'b0;
  end

  logic        ge;
  logic [24:0] rem_sub, rem_next;

  // One restoring-division step: subtract when the divisor fits, then shift
  always_comb begin
    ge       = (rem >= {1'b0, mx});
    rem_sub  = ge ? (rem - {1'b0, mx}) : rem;
    rem_next = rem_sub << 1;
  end

  logic               norm, guard, sticky, round_up;
  logic [23:0]        mant24;
  logic [24:0]        mant_sum;
  logic [22:0]        frac_fin;
  logic signed [9:0]  e_norm, e_fin;
  logic [31:0]        round_q;

  // Normalise on the leading quotient bit, round to nearest even, range check.
  // The bit below guard is folded into sticky so ties are only seen when exact.
  always_comb begin
    norm     = quo[QBITS-1];
    mant24   = norm ? quo[25:2] : quo[24:1];
    guard    = norm ? quo[1] : quo[0];
    sticky   = (rem != '0) || (norm && quo[0]);
    e_norm   = norm ? e : (e - 10'sd1);
    round_up = guard && (sticky || mant24[0]);
    mant_sum = {1'b0, mant24} + {24'd0, round_up};
    if (mant_sum[24]) begin
      frac_fin = mant_sum[23:1];
      e_fin    = e_norm + 10'sd1;
    end else begin
      frac_fin = mant_sum[22:0];
      e_fin    = e_norm;
    end
    if (e_fin >= 10'sd255)
      round_q = {sign, 8'hff, 23'd0};
    else if (e_fin <= 10'sd0)
      round_q = {sign, 31'd0};
    else
      round_q = {sign, e_fin[7:0], frac_fin};
  end

  // Control FSM and datapath registers, outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      io_in_ready  <= 1'b1;
      io_out_valid <= 1'b0;
      io_out_q     <= '0;
      io_out_xneg  <= 1'b0;
      io_out_yneg  <= 1'b0;
      y_r          <= '0;
      x_r          <= '0;
      mx           <= '0;
      rem          <= '0;
      quo          <= '0;
      e            <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            y_r         <= io_in_y;
            x_r         <= io_in_x;
            io_in_ready <= 1'b0;
            state       <= UNPACK;
          end
        end
        UNPACK: begin
          if (special) begin
            io_out_q     <= special_q;
            io_out_xneg  <= x_r[31];
            io_out_yneg  <= y_r[31];
            io_out_valid <= 1'b1;
            state        <= DONE;
          end else begin
            mx    <= {1'b1, x_r[22:0]};
            rem   <= {2'b01, y_r[22:0]};
            quo   <= '0;
            cnt   <= '0;
            e     <= e_unpack;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          quo <= {quo[QBITS-2:0], ge};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(QBITS - 1))
            state <= ROUND;
        end
        ROUND: begin
          io_out_q     <= round_q;
          io_out_xneg  <= x_r[31];
          io_out_yneg  <= y_r[31];
          io_out_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (io_out_ready) begin
            io_out_valid <= 1'b0;
            io_in_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atan2_ratio_div.sv
// Self-checking bench for atan2_ratio_div: directed vectors, randomized
// operands against an exact-integer division model, backpressure and reset.
module tb_atan2_ratio_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_y;
  logic [31:0] io_in_x;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_q;
  logic        io_out_xneg;
  logic        io_out_yneg;

  int n_checks = 0;
  int n_pass   = 0;

  atan2_ratio_div #(
    .QBITS(26),
    .NAN_CANON(32'h7fc00000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_y(io_in_y),
    .io_in_x(io_in_x),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_q(io_out_q),
    .io_out_xneg(io_out_xneg),
    .io_out_yneg(io_out_yneg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, want);
  endtask

  // Reference: exact quotient via wide integer division, then RNE on the
  // discarded bits. Result bit 32 flags the special-case fast path.
  function automatic logic [32:0] model(input logic [31:0] y, input logic [31:0] x);
    int unsigned ey = y[30:23];
    int unsigned ex = x[30:23];
    logic s = y[31] ^ x[31];
    bit yz = (ey == 0), xz = (ex == 0);
    bit yi = (ey == 255) && (y[22:0] == 0), xi = (ex == 255) && (x[22:0] == 0);
    bit yn = (ey == 255) && (y[22:0] != 0), xn = (ex == 255) && (x[22:0] != 0);
    longint unsigned my, mx, num, qt, rm, mant, rest, half;
    int e, sh;
    bit up;
    if (yn || xn || (yi && xi)) return {1'b1, 32'h7fc00000};
    if (xz && yz)               return {1'b1, 32'h00000000};
    if (xz || yi)               return {1'b1, s, 31'h7f800000};
    if (xi || yz)               return {1'b1, s, 31'h0};
    my  = 64'h800000 | 64'(y[22:0]);
    mx  = 64'h800000 | 64'(x[22:0]);
    num = my << 39;
    qt  = num / mx;
    rm  = num % mx;
    e   = int'(ey) - int'(ex) + 127;
    if (qt >= (64'd1 << 39)) sh = 16;
    else begin sh = 15; e = e - 1; end
    mant = qt >> sh;
    rest = qt & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    up   = (rest > half) || ((rest == half) && ((rm != 0) || mant[0]));
    mant = mant + 64'(up);
    if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
    if (e >= 255) return {1'b0, s, 31'h7f800000};
    if (e <= 0)   return {1'b0, s, 31'h0};
    return {1'b0, s, 8'(e), mant[22:0]};
  endfunction

  // Issue one operation from a negedge, time its result, optionally hold off
  // the consumer for 'hold' cycles while offering a competing input.
  task automatic run_op(input string tag, input logic [31:0] y, input logic [31:0] x,
                        input logic [31:0] want_q, input int want_lat, input int hold);
    int n;
    bit busy_ok;
    check({tag, ".ready_idle"}, 32'(io_in_ready), 32'd1);
    io_in_y     = y;
    io_in_x     = x;
    io_in_valid = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
    io_in_y     = $urandom;
    io_in_x     = $urandom;
    n       = 1;
    busy_ok = 1'b1;
    while (!io_out_valid && n < 40) begin
      if (io_in_ready) busy_ok = 1'b0;
      @(negedge clock);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(want_lat));
    check({tag, ".busy_ready"}, 32'(busy_ok && !io_in_ready), 32'd1);
    check({tag, ".q"}, io_out_q, want_q);
    check({tag, ".xneg"}, 32'(io_out_xneg), 32'(x[31]));
    check({tag, ".yneg"}, 32'(io_out_yneg), 32'(y[31]));
    for (int i = 0; i < hold; i++) begin
      io_in_valid = 1'b1;
      io_in_y     = $urandom;
      io_in_x     = $urandom;
      @(negedge clock);
      check({tag, ".bp_q"}, io_out_q, want_q);
      check({tag, ".bp_side"}, 32'({io_out_xneg, io_out_yneg}), 32'({x[31], y[31]}));
      check({tag, ".bp_flags"}, 32'({io_out_valid, io_in_ready}), 32'b10);
    end
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    check({tag, ".post_hs"}, 32'({io_out_valid, io_in_ready}), 32'b01);
  endtask

  function automatic logic [31:0] rand_operand();
    int unsigned cls = $urandom_range(0, 9);
    logic [7:0]  ex;
    logic [22:0] fr = 23'($urandom);
    case (cls)
      0: ex = 8'h00;
      1: begin ex = 8'hff; fr = '0; end
      2: begin ex = 8'hff; fr[0] = 1'b1; end
      3: ex = 8'($urandom_range(230, 254));
      4: ex = 8'($urandom_range(1, 25));
      5: fr = '0;
      default: ex = 8'($urandom_range(100, 154));
    endcase
    if (cls == 5) ex = 8'($urandom_range(1, 254));
    return {1'($urandom), ex, fr};
  endfunction

  logic [31:0] dy [9] = '{32'h3f800000, 32'h40400000, 32'h3f800000, 32'hc0a00000, 32'h00000000,
                          32'h7fc00001, 32'h7f000000, 32'h00800000, 32'h3f800000};
  logic [31:0] dx [9] = '{32'h40000000, 32'hc0000000, 32'h40400000, 32'h00000000, 32'h00000000,
                          32'h3f800000, 32'h00800000, 32'h7f000000, 32'h00000001};
  logic [31:0] dq [9] = '{32'h3f000000, 32'hbfc00000, 32'h3eaaaaab, 32'hff800000, 32'h00000000,
                          32'h7fc00000, 32'h7f800000, 32'h00000000, 32'h7f800000};
  int          dl [9] = '{29, 29, 29, 2, 2, 2, 29, 29, 2};

  initial begin
    logic [31:0] ry, rx;
    logic [32:0] m;
    int  n;
    bit  quiet;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_y      = '0;
    io_in_x      = '0;
    io_out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.ready", 32'(io_in_ready), 32'd1);
    check("rst.valid", 32'(io_out_valid), 32'd0);
    check("rst.q", io_out_q, 32'd0);
    check("rst.side", 32'({io_out_xneg, io_out_yneg}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("dir%0d", i), dy[i], dx[i], dq[i], dl[i], (i == 0) ? 5 : 0);

    // Reset lands while the divide loop is running
    io_in_y = 32'h3f800000;
    io_in_x = 32'h40400000;
    io_in_valid = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
    for (n = 1; n < 10; n++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (io_out_valid) quiet = 1'b0;
      @(negedge clock);
    end
    check("abort.no_valid", 32'(quiet), 32'd1);
    check("abort.ready", 32'(io_in_ready), 32'd1);
    check("abort.q", io_out_q, 32'd0);
    run_op("after_abort", 32'h40400000, 32'hc0000000, 32'hbfc00000, 29, 0);

    for (int i = 0; i < 60; i++) begin
      ry = rand_operand();
      rx = rand_operand();
      m  = model(ry, rx);
      run_op($sformatf("rnd%0d", i), ry, rx, m[31:0], m[32] ? 2 : 29, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
